// File: rtl/fta_respbuf_rr.sv
// Per-channel response FIFOs merged onto one registered output by a round-robin or fixed-priority arbiter.
// Latency 2 edges (push edge, then load edge); output held while ack & !resp_rdy, full FIFOs drop and flag ovf.
package fta_pkg;
  typedef struct packed {
    logic         ack;
    logic         stall;
    logic         next;
    logic [3:0]   pri;
    logic [1:0]   err;
    logic [7:0]   tid;
    logic [127:0] data;
  } fta_cmd_response128_t;

  typedef struct packed {
    logic        ack;
    logic        stall;
    logic        next;
    logic [3:0]  pri;
    logic [1:0]  err;
    logic [7:0]  tid;
    logic [63:0] data;
  } fta_cmd_response64_t;

  typedef struct packed {
    logic        ack;
    logic        stall;
    logic        next;
    logic [3:0]  pri;
    logic [1:0]  err;
    logic [7:0]  tid;
    logic [31:0] data;
  } fta_cmd_response32_t;
endpackage

module fta_respbuf_rr #(
  parameter int  CHANNELS = 8,
  parameter int  DEPTH    = 4,
  parameter int  AFULL    = DEPTH - 1,
  parameter int  ARB_MODE = 0,
  parameter type resp_t   = fta_pkg::fta_cmd_response128_t
) (
  input  logic                clk,
  input  logic                rst,
  input  resp_t               resp [CHANNELS],
  output resp_t               resp_o,
  input  logic                resp_rdy,
  output logic [CHANNELS-1:0] afull_o,
  output logic [CHANNELS-1:0] ovf_o,
  input  logic [CHANNELS-1:0] ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(CHANNELS);

  resp_t               r_mem  [CHANNELS][DEPTH];
  logic [AW-1:0]       r_wptr [CHANNELS];
  logic [AW-1:0]       r_rptr [CHANNELS];
  logic [CW-1:0]       r_cnt  [CHANNELS];
  logic [PW-1:0]       r_ptr;
  resp_t               r_out;
  logic [CHANNELS-1:0] r_afull;
  logic [CHANNELS-1:0] r_ovf;

  logic                w_free;
  logic [CHANNELS-1:0] w_nempty;
  logic                w_gnt_vld;
  logic [PW-1:0]       w_gnt_ch;
  logic [CHANNELS-1:0] w_pop;
  logic [CHANNELS-1:0] w_push;
  logic [CHANNELS-1:0] w_drop;
  logic [CW-1:0]       w_cnt_nxt [CHANNELS];
  resp_t               w_idle;
  resp_t               w_load;

  assign resp_o  = r_out;
  assign afull_o = r_afull;
  assign ovf_o   = r_ovf;
  assign w_free  = !r_out.ack || resp_rdy;

  always_comb begin
    w_idle     = '0;
    w_idle.pri = 4'hF;
  end

  // Search order starts one past the last grant; fixed mode always scans from channel 0.
  always_comb begin : p_arb
    int idx;
    idx       = 0;
    w_gnt_vld = 1'b0;
    w_gnt_ch  = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = (ARB_MODE == 1) ? (i - 1) : ((int'(r_ptr) + i) % CHANNELS);
      if (!w_gnt_vld && w_nempty[PW'(idx)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_ch  = PW'(idx);
      end
    end
  end

  always_comb begin
    w_load       = r_mem[w_gnt_ch][r_rptr[w_gnt_ch]];
    w_load.ack   = 1'b1;
    w_load.stall = 1'b0;
    w_load.next  = 1'b0;
  end

  // A full FIFO still accepts when the same channel is popped on this edge.
  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      w_nempty[ch]  = (r_cnt[ch] != '0);
      w_pop[ch]     = w_free && w_gnt_vld && (w_gnt_ch == PW'(ch));
      w_push[ch]    = resp[ch].ack && ((r_cnt[ch] != CW'(DEPTH)) || w_pop[ch]);
      w_drop[ch]    = resp[ch].ack && !w_push[ch];
      w_cnt_nxt[ch] = r_cnt[ch] + CW'(w_push[ch]) - CW'(w_pop[ch]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        r_wptr[ch] <= '0;
        r_rptr[ch] <= '0;
        r_cnt[ch]  <= '0;
      end
      r_ptr   <= PW'(CHANNELS - 1);
      r_out   <= w_idle;
      r_afull <= '0;
      r_ovf   <= '0;
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (w_push[ch]) r_wptr[ch] <= r_wptr[ch] + AW'(1);
        if (w_pop[ch])  r_rptr[ch] <= r_rptr[ch] + AW'(1);
        r_cnt[ch]   <= w_cnt_nxt[ch];
        r_afull[ch] <= (w_cnt_nxt[ch] >= CW'(AFULL));
      end
      r_ovf <= (r_ovf & ~ovf_clr) | w_drop;
      if (w_free) begin
        if (w_gnt_vld) begin
          r_out <= w_load;
          r_ptr <= w_gnt_ch;
        end else begin
          r_out <= w_idle;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (rst && w_push[ch]) r_mem[ch][r_wptr[ch]] <= resp[ch];
    end
  end
endmodule

// File: tb/tb_fta_respbuf_rr.sv
// Scoreboard bench for fta_respbuf_rr: expected responses queued in grant order, compared on each handshake.
module tb_fta_respbuf_rr;
  import fta_pkg::*;
  localparam int CH = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  fta_cmd_response128_t resp [CH];
  fta_cmd_response128_t resp_o;
  logic                 resp_rdy;
  logic [CH-1:0]        afull_o;
  logic [CH-1:0]        ovf_o;
  logic [CH-1:0]        ovf_clr;

  fta_cmd_response128_t exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  fta_respbuf_rr #(.CHANNELS(CH), .DEPTH(4), .AFULL(3), .ARB_MODE(0),
                   .resp_t(fta_cmd_response128_t)) dut (
    .clk(clk), .rst(rst), .resp(resp), .resp_o(resp_o), .resp_rdy(resp_rdy),
    .afull_o(afull_o), .ovf_o(ovf_o), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic fta_cmd_response128_t mk(input int ch, input int seq);
    fta_cmd_response128_t r;
    r       = '0;
    r.ack   = 1'b1;
    r.stall = 1'b1;
    r.next  = 1'b1;
    r.pri   = 4'(seq);
    r.err   = 2'(ch);
    r.tid   = 8'(ch * 16 + seq);
    r.data  = {4{32'(ch * 1000 + seq) ^ 32'hA5A5_0000}};
    return r;
  endfunction

  function automatic fta_cmd_response128_t expd(input fta_cmd_response128_t r);
    fta_cmd_response128_t e;
    e       = r;
    e.ack   = 1'b1;
    e.stall = 1'b0;
    e.next  = 1'b0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    for (int c = 0; c < CH; c++) resp[c] = '0;
  endtask

  task automatic drive(input int ch, input int seq);
    resp[ch] = mk(ch, seq);
    exp_q.push_back(expd(resp[ch]));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_in();
    ovf_clr = '0;
    repeat (2) tick();
    exp_q.delete();
    rst = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    repeat (2) tick();
    @(negedge clk);
    chk({"drain_", tag}, 160'(exp_q.size()), 160'd0);
    chk({"idle_", tag}, 160'(resp_o.ack), 160'd0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && resp_o.ack && resp_rdy) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra", 160'(exp_q.size()), 160'd1);
      end else begin
        fta_cmd_response128_t e;
        e = exp_q.pop_front();
        chk("sb_tid", 160'(resp_o.tid), 160'(e.tid));
        chk("sb_resp", 160'(resp_o), 160'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    fta_cmd_response128_t e;
    rst      = 1'b0;
    resp_rdy = 1'b1;
    ovf_clr  = '0;
    for (int c = 0; c < CH; c++) resp[c] = mk(c, 1);
    repeat (2) tick();
    @(negedge clk);
    chk("rst_ack", 160'(resp_o.ack), 160'd0);
    chk("rst_pri", 160'(resp_o.pri), 160'hF);
    chk("rst_afull", 160'(afull_o), 160'd0);
    chk("rst_ovf", 160'(ovf_o), 160'd0);
    clear_in();
    tick();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_nostore", 160'(resp_o.ack), 160'd0);

    // Latency: one push, output visible exactly one edge later, idle the edge after
    do_reset();
    resp_rdy = 1'b1;
    repeat (7) tick();
    resp[3]     = mk(3, 5);
    resp[3].tid = 8'd5;
    exp_q.push_back(expd(resp[3]));
    tick();
    clear_in();
    @(negedge clk);
    chk("lat_n_ack", 160'(resp_o.ack), 160'd0);
    tick();
    @(negedge clk);
    chk("lat_n1_ack", 160'(resp_o.ack), 160'd1);
    chk("lat_n1_tid", 160'(resp_o.tid), 160'd5);
    tick();
    @(negedge clk);
    chk("lat_n2_ack", 160'(resp_o.ack), 160'd0);
    chk("lat_n2_pri", 160'(resp_o.pri), 160'hF);

    // Round robin: grant order 0,2,5,0,2,5
    do_reset();
    resp_rdy = 1'b1;
    for (int s = 0; s < 2; s++) begin
      drive(0, s); drive(2, s); drive(5, s);
      tick();
    end
    clear_in();
    wait_drain("rr");

    // Backpressure: ch1 held, then ch1 and ch4 in order
    do_reset();
    resp_rdy = 1'b0;
    drive(1, 0); drive(4, 0);
    tick();
    clear_in();
    tick();
    e = mk(1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_ack", 160'(resp_o.ack), 160'd1);
      chk("bp_hold_tid", 160'(resp_o.tid), 160'(e.tid));
      tick();
    end
    resp_rdy = 1'b1;
    wait_drain("bp");

    // Overflow on ch2 with output stalled
    do_reset();
    resp_rdy = 1'b0;
    for (int s = 1; s <= 6; s++) begin
      if (s <= 5) drive(2, s);
      else resp[2] = mk(2, s);
      tick();
      @(negedge clk);
      if (s == 3) chk("ovf_afull_c2", 160'(afull_o[2]), 160'd0);
      if (s == 4) chk("ovf_afull_c3", 160'(afull_o[2]), 160'd1);
      if (s == 5) chk("ovf_pre", 160'(ovf_o[2]), 160'd0);
      if (s == 6) chk("ovf_set", 160'(ovf_o), 160'h04);
    end
    clear_in();
    e = mk(2, 1);
    chk("ovf_held_tid", 160'(resp_o.tid), 160'(e.tid));
    tick();
    ovf_clr[2] = 1'b1;
    tick();
    ovf_clr = '0;
    @(negedge clk);
    chk("ovf_clr", 160'(ovf_o), 160'd0);
    resp_rdy = 1'b1;
    wait_drain("ovf");
    chk("ovf_afull_end", 160'(afull_o), 160'd0);

    // Full FIFO on ch7 accepts a push when popped in the same cycle
    do_reset();
    resp_rdy = 1'b0;
    for (int s = 1; s <= 5; s++) begin
      drive(7, s);
      tick();
    end
    clear_in();
    @(negedge clk);
    chk("full_afull", 160'(afull_o[7]), 160'd1);
    drive(7, 6);
    resp_rdy = 1'b1;
    tick();
    clear_in();
    @(negedge clk);
    chk("full_noovf", 160'(ovf_o), 160'd0);
    chk("full_cnt4", 160'(afull_o[7]), 160'd1);
    wait_drain("full");
    chk("full_noovf_end", 160'(ovf_o), 160'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
